// File: rtl/nibble_sequencer.sv
// Multi-nibble hex display sequencer: shows one digit at a time, MSB first, each held then blanked.
// Latency: a value accepted at a clock edge is on binary/blank/dp right after that edge; each digit lasts HOLD_CYCLES+GAP_CYCLES.
// Backpressure: load_ready is high only in IDLE; load_valid while busy is ignored (no capture, no queuing).
// Optional feature: define NIBSEQ_ZERO_SUPPRESS_EN to skip leading zero nibbles (an all-zero value still shows one "0").
module nibble_sequencer #(
  parameter int DIGITS      = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [3:0]            binary,
  output logic                  blank,
  output logic                  dp,
  output logic                  busy
);

  localparam int IW   = $clog2(DIGITS) + 1;
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] GAP_INIT  = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_TOP   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   data_q, data_d;
  logic [3:0]            binary_d;
  logic                  blank_d;
  logic                  dp_d;
  logic [IW-1:0]         start_idx;

  // Select nibble i of a value; out-of-range index yields zero.
  function automatic logic [3:0] nib_at(input logic [4*DIGITS-1:0] d, input logic [IW-1:0] i);
    nib_at = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (i == IW'(k)) nib_at = d[k*4 +: 4];
    end
  endfunction

  // Handshake status comes straight from the state register.
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);

  // First index to display for the value currently offered on load_data.
  always_comb begin
    start_idx = IDX_TOP;
`ifdef NIBSEQ_ZERO_SUPPRESS_EN
    // Ascending scan: the last nonzero nibble found is the highest one; all-zero leaves index 0.
    start_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_data[i*4 +: 4] != 4'h0) start_idx = IW'(i);
    end
`endif
  end

  // Next-state and next-output logic for the display sequence.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    binary_d = binary;
    blank_d  = blank;
    dp_d     = dp;

    case (state_q)
      IDLE: begin
        binary_d = 4'h0;
        blank_d  = 1'b1;
        dp_d     = 1'b0;
        if (load_valid) begin
          data_d   = load_data;
          idx_d    = start_idx;
          cnt_d    = HOLD_INIT;
          binary_d = nib_at(load_data, start_idx);
          blank_d  = 1'b0;
          dp_d     = 1'b1;
          state_d  = SHOW;
        end
      end

      SHOW: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = GAP_INIT;
          blank_d = 1'b1;
          dp_d    = 1'b0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      GAP: begin
        if (cnt_q == CNT_ONE) begin
          if (idx_q == '0) begin
            cnt_d    = '0;
            binary_d = 4'h0;
            blank_d  = 1'b1;
            dp_d     = 1'b0;
            state_d  = IDLE;
          end else begin
            // dp stays low: only the first shown digit is marked.
            idx_d    = idx_q - IDX_ONE;
            cnt_d    = HOLD_INIT;
            binary_d = nib_at(data_q, idx_q - IDX_ONE);
            blank_d  = 1'b0;
            dp_d     = 1'b0;
            state_d  = SHOW;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        cnt_d    = '0;
        idx_d    = '0;
        binary_d = 4'h0;
        blank_d  = 1'b1;
        dp_d     = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State, counters, captured value and registered display outputs; reset abandons any sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      binary  <= 4'h0;
      blank   <= 1'b1;
      dp      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      binary  <= binary_d;
      blank   <= blank_d;
      dp      <= dp_d;
    end
  end

endmodule

// File: tb/tb_nibble_sequencer.sv
// Directed bench for nibble_sequencer at defaults (DIGITS=4, HOLD=8, GAP=2).
// Table of single-cycle vectors, then hand-written multi-cycle sequences.
// Expected digits follow NIBSEQ_ZERO_SUPPRESS_EN when the bench is built with it.
module tb_nibble_sequencer;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  binary;
  logic        blank;
  logic        dp;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  nibble_sequencer #(
    .DIGITS      (4),
    .HOLD_CYCLES (8),
    .GAP_CYCLES  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .binary     (binary),
    .blank      (blank),
    .dp         (dp),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] dat;
    logic [3:0]  e_bin;
    logic        e_blank;
    logic        e_dp;
    logic        e_busy;
    logic        e_rdy;
  } vec_t;

  vec_t vecs [11];

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] eb, input logic ebl,
                     input logic edp, input logic ebusy, input logic erdy);
    checks++;
    if ({binary, blank, dp, busy, load_ready} !== {eb, ebl, edp, ebusy, erdy}) begin
      failures++;
      $display("FAIL %s: got bin=%h blank=%b dp=%b busy=%b rdy=%b, want bin=%h blank=%b dp=%b busy=%b rdy=%b",
               name, binary, blank, dp, busy, load_ready, eb, ebl, edp, ebusy, erdy);
    end
  endtask

  // Check a sequence of n shown digits (taken from the low n nibbles of val, MSB first),
  // entered just after the capture edge. hold keeps load_valid high; inj_k pulses a
  // competing load of FFFF after that cycle; abort_k asserts reset after that cycle.
  task automatic check_seq(input string tag, input logic [15:0] val, input int n,
                           input bit hold, input int inj_k, input int abort_k);
    logic [15:0] sh;
    logic [3:0]  dig;
    int d, ph;
    for (int k = 0; k < n*10; k++) begin
      if (k > 0) step();
      d   = k / 10;
      ph  = k % 10;
      sh  = val >> ((n - 1 - d) * 4);
      dig = sh[3:0];
      if (ph < 8)
        chk($sformatf("%s show d%0d c%0d", tag, d, ph), dig, 1'b0, (d == 0), 1'b1, 1'b0);
      else
        chk($sformatf("%s gap d%0d c%0d", tag, d, ph), dig, 1'b1, 1'b0, 1'b1, 1'b0);
      if (!hold) load_valid = 1'b0;
      if (k == inj_k) begin
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
      end
      if (k == abort_k) begin
        reset = 1'b1;
        step();
        chk($sformatf("%s after reset", tag), 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        return;
      end
    end
    step();
    chk($sformatf("%s idle", tag), 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic load(input logic [15:0] val);
    load_valid = 1'b1;
    load_data  = val;
    step();
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0000;

    //            rst   vld   dat       bin   blank dp    busy  rdy
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 16'h1A2F, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 16'h1A2F, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 16'h1A2F, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'hFFFF, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef NIBSEQ_ZERO_SUPPRESS_EN
    vecs[8]  = '{1'b0, 1'b1, 16'h0050, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0};
`else
    vecs[8]  = '{1'b0, 1'b1, 16'h0050, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
`endif
    vecs[9]  = '{1'b1, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 11; i++) begin
      reset      = vecs[i].rst;
      load_valid = vecs[i].vld;
      load_data  = vecs[i].dat;
      step();
      chk($sformatf("vec%0d", i), vecs[i].e_bin, vecs[i].e_blank, vecs[i].e_dp,
          vecs[i].e_busy, vecs[i].e_rdy);
    end
    load_valid = 1'b0;

    // Idle with no load stays idle.
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("idle c%0d", i), 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    end

    // Single-cycle load, full sequence.
    load(16'h1A2F);
    check_seq("1A2F", 16'h1A2F, 4, 1'b0, -1, -1);

    // Load while busy is ignored.
    load(16'h1234);
    check_seq("1234", 16'h1234, 4, 1'b0, 4, -1);

    // Reset in the 3rd cycle of digit A, then a fresh load.
    load(16'h1A2F);
    check_seq("1A2F rst", 16'h1A2F, 4, 1'b0, -1, 12);
    load(16'h0007);
`ifdef NIBSEQ_ZERO_SUPPRESS_EN
    check_seq("0007", 16'h0007, 1, 1'b0, -1, -1);
`else
    check_seq("0007", 16'h0007, 4, 1'b0, -1, -1);
`endif

    // Leading zeros and all-zero value.
    load(16'h00A5);
`ifdef NIBSEQ_ZERO_SUPPRESS_EN
    check_seq("00A5", 16'h00A5, 2, 1'b0, -1, -1);
`else
    check_seq("00A5", 16'h00A5, 4, 1'b0, -1, -1);
`endif
    load(16'h0000);
`ifdef NIBSEQ_ZERO_SUPPRESS_EN
    check_seq("0000", 16'h0000, 1, 1'b0, -1, -1);
`else
    check_seq("0000", 16'h0000, 4, 1'b0, -1, -1);
`endif

    // Valid held high: re-accepted after one IDLE cycle each time.
    load(16'hBEEF);
    check_seq("BEEF r0", 16'hBEEF, 4, 1'b1, -1, -1);
    step();
    check_seq("BEEF r1", 16'hBEEF, 4, 1'b1, -1, -1);
    step();
    check_seq("BEEF r2", 16'hBEEF, 4, 1'b0, -1, -1);
    step();
    chk("post hold idle", 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
